// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Parametrised single-clock FIFO used as the standard elastic buffer between
// streaming stages. Generic data width, power-of-two depth, occupancy count,
// programmable almost-full/almost-empty flags and push-through when full.
//
// Optional feature macro: FIFO_ERR_EN
//   defined   : sticky io_overflow / io_underflow flags, cleared by io_clr_err
//   undefined : io_overflow / io_underflow tied 0, io_clr_err ignored
//
// Ports
//   clk             in   1         clock, rising edge
//   reset           in   1         asynchronous, active-low reset
//   io_din          in   DATA_W    write data
//   io_push         in   1         write request
//   io_pop          in   1         read request (consumes io_dout)
//   io_dout         out  DATA_W    head-of-queue data, read straight from storage
//   io_empty        out  1         count == 0
//   io_full         out  1         count == DEPTH
//   io_almost_empty out  1         count <= AE_LEVEL
//   io_almost_full  out  1         count >= AF_LEVEL
//   io_count        out  ADDR_W+1  occupancy 0..DEPTH
//   io_overflow     out  1         sticky push-on-full flag
//   io_underflow    out  1         sticky pop-on-empty flag
//   io_clr_err      in   1         clears the sticky flags
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter  int DATA_W   = 8,
   parameter  int DEPTH    = 16,
   parameter  int AF_LEVEL = 14,
   parameter  int AE_LEVEL = 1,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] io_din,
   input  logic              io_push,
   input  logic              io_pop,
   output logic [DATA_W-1:0] io_dout,
   output logic              io_empty,
   output logic              io_full,
   output logic              io_almost_empty,
   output logic              io_almost_full,
   output logic [ADDR_W:0]   io_count,
   output logic              io_overflow,
   output logic              io_underflow,
   input  logic              io_clr_err
);

   localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_LEVEL);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              empty_s, full_s;
   logic              push_ok_s, pop_ok_s;

   // Extra wrap bit on each pointer distinguishes full from empty.
   assign empty_s   = (wr_ptr_q == rd_ptr_q);
   assign full_s    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                      (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

   // A pop frees the slot the push needs, so push is accepted on full+pop.
   assign pop_ok_s  = io_pop & ~empty_s;
   assign push_ok_s = io_push & (~full_s | io_pop);

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + PTR_ONE;
         2'b01:   count_d = count_q - PTR_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers, discarded immediately on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= {(ADDR_W+1){1'b0}};
         rd_ptr_q <= {(ADDR_W+1){1'b0}};
         count_q  <= {(ADDR_W+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= io_din;
      end
   end

   // Head of queue is read straight from storage (zero-cycle read).
   assign io_dout         = mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign io_empty        = empty_s;
   assign io_full         = full_s;
   assign io_count        = count_q;
   assign io_almost_empty = (count_q <= AE_LVL);
   assign io_almost_full  = (count_q >= AF_LVL);

`ifdef FIFO_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Sticky error next-state; a clear wins over a same-cycle set. A pop on
   // empty that coincides with a push is treated as a push, not an error.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (io_clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (io_push & full_s & ~io_pop) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end
         if (io_pop & empty_s & ~io_push) begin
            underflow_d = 1'b1;
         end else begin
            underflow_d = underflow_q;
         end
      end
   end

   // Sticky error registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign io_overflow  = overflow_q;
   assign io_underflow = underflow_q;
`else
   logic unused_clr_err_s;

   assign unused_clr_err_s = io_clr_err;
   assign io_overflow      = 1'b0;
   assign io_underflow     = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Directed self-checking bench for sync_fifo at default parameters
// (DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=1). Status is compared as a
// packed vector {empty, full, almost_empty, almost_full, count[4:0]}.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

   logic       clk;
   logic       reset;
   logic [7:0] io_din;
   logic       io_push;
   logic       io_pop;
   logic [7:0] io_dout;
   logic       io_empty;
   logic       io_full;
   logic       io_almost_empty;
   logic       io_almost_full;
   logic [4:0] io_count;
   logic       io_overflow;
   logic       io_underflow;
   logic       io_clr_err;

   int vec_cnt;
   int err_cnt;

   logic [8:0] stat_s;
   assign stat_s = {io_empty, io_full, io_almost_empty, io_almost_full, io_count};

   sync_fifo dut (
      .clk             (clk),
      .reset           (reset),
      .io_din          (io_din),
      .io_push         (io_push),
      .io_pop          (io_pop),
      .io_dout         (io_dout),
      .io_empty        (io_empty),
      .io_full         (io_full),
      .io_almost_empty (io_almost_empty),
      .io_almost_full  (io_almost_full),
      .io_count        (io_count),
      .io_overflow     (io_overflow),
      .io_underflow    (io_underflow),
      .io_clr_err      (io_clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected status vector for a given occupancy.
   function automatic logic [8:0] exp_stat(input int cnt);
      logic [4:0] c;
      c = 5'(cnt);
      return {(cnt == 0), (cnt == 16), (cnt <= 1), (cnt >= 14), c};
   endfunction

   // One clock cycle with the given request lines; returns 1 ns after the edge.
   task automatic drive(input logic push, input logic pop, input logic clr,
                        input logic [7:0] din);
      io_push    = push;
      io_pop     = pop;
      io_clr_err = clr;
      io_din     = din;
      @(posedge clk);
      #1;
      io_push    = 1'b0;
      io_pop     = 1'b0;
      io_clr_err = 1'b0;
   endtask

   task automatic test_reset;
      vec_cnt++;
      if (stat_s !== exp_stat(0) || io_overflow !== 1'b0 || io_underflow !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_state: got stat=%b ovf=%b unf=%b, need stat=%b ovf=0 unf=0",
                  stat_s, io_overflow, io_underflow, exp_stat(0));
      end
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
      vec_cnt++;
      if (stat_s !== exp_stat(3)) begin
         err_cnt++;
         $display("FAIL reset_prefill: got stat=%b, need %b", stat_s, exp_stat(3));
      end
      // Assert reset mid-cycle and look before any clock edge.
      #2 reset = 1'b0;
      #1;
      vec_cnt++;
      if (stat_s !== exp_stat(0)) begin
         err_cnt++;
         $display("FAIL reset_async: got stat=%b, need %b", stat_s, exp_stat(0));
      end
      #3 reset = 1'b1;
   endtask

   task automatic test_fill_drain;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'(i));
         vec_cnt++;
         if (stat_s !== exp_stat(i + 1) || io_dout !== 8'h00) begin
            err_cnt++;
            $display("FAIL fill_%0d: got stat=%b dout=%h, need stat=%b dout=00",
                     i, stat_s, io_dout, exp_stat(i + 1));
         end
      end
      // Push on full without pop is dropped.
      drive(1'b1, 1'b0, 1'b0, 8'hEE);
      vec_cnt++;
      if (stat_s !== exp_stat(16) || io_dout !== 8'h00) begin
         err_cnt++;
         $display("FAIL full_push_drop: got stat=%b dout=%h, need stat=%b dout=00",
                  stat_s, io_dout, exp_stat(16));
      end
      for (int i = 0; i < 16; i++) begin
         vec_cnt++;
         if (io_dout !== 8'(i)) begin
            err_cnt++;
            $display("FAIL drain_data_%0d: got %h, need %h", i, io_dout, 8'(i));
         end
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         vec_cnt++;
         if (stat_s !== exp_stat(15 - i)) begin
            err_cnt++;
            $display("FAIL drain_stat_%0d: got %b, need %b", i, stat_s, exp_stat(15 - i));
         end
      end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
      for (int i = 0; i < 10; i++) begin
         vec_cnt++;
         if (io_dout !== 8'(8'h20 + i)) begin
            err_cnt++;
            $display("FAIL wrap_a_%0d: got %h, need %h", i, io_dout, 8'(8'h20 + i));
         end
         drive(1'b0, 1'b1, 1'b0, 8'h00);
      end
      for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      vec_cnt++;
      if (stat_s !== exp_stat(12)) begin
         err_cnt++;
         $display("FAIL wrap_count: got %b, need %b", stat_s, exp_stat(12));
      end
      for (int i = 0; i < 12; i++) begin
         vec_cnt++;
         if (io_dout !== 8'(8'h40 + i)) begin
            err_cnt++;
            $display("FAIL wrap_b_%0d: got %h, need %h", i, io_dout, 8'(8'h40 + i));
         end
         drive(1'b0, 1'b1, 1'b0, 8'h00);
      end
      vec_cnt++;
      if (stat_s !== exp_stat(0)) begin
         err_cnt++;
         $display("FAIL wrap_empty: got %b, need %b", stat_s, exp_stat(0));
      end
   endtask

   task automatic test_full_push_pop;
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
      drive(1'b1, 1'b1, 1'b0, 8'hAA);
      vec_cnt++;
      if (stat_s !== exp_stat(16) || io_dout !== 8'h61) begin
         err_cnt++;
         $display("FAIL full_push_pop: got stat=%b dout=%h, need stat=%b dout=61",
                  stat_s, io_dout, exp_stat(16));
      end
      for (int i = 0; i < 16; i++) begin
         vec_cnt++;
         if (io_dout !== ((i == 15) ? 8'hAA : 8'(8'h61 + i))) begin
            err_cnt++;
            $display("FAIL fpp_drain_%0d: got %h, need %h", i, io_dout,
                     ((i == 15) ? 8'hAA : 8'(8'h61 + i)));
         end
         drive(1'b0, 1'b1, 1'b0, 8'h00);
      end
      vec_cnt++;
      if (stat_s !== exp_stat(0)) begin
         err_cnt++;
         $display("FAIL fpp_empty: got %b, need %b", stat_s, exp_stat(0));
      end
   endtask

   task automatic test_empty_push_pop;
      drive(1'b1, 1'b1, 1'b0, 8'h55);
      vec_cnt++;
      if (stat_s !== exp_stat(1) || io_dout !== 8'h55 || io_underflow !== 1'b0) begin
         err_cnt++;
         $display("FAIL empty_push_pop: got stat=%b dout=%h unf=%b, need stat=%b dout=55 unf=0",
                  stat_s, io_dout, io_underflow, exp_stat(1));
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      // Pop on empty is ignored; a following push must land at the head.
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      vec_cnt++;
      if (stat_s !== exp_stat(0)) begin
         err_cnt++;
         $display("FAIL empty_pop: got %b, need %b", stat_s, exp_stat(0));
      end
      drive(1'b1, 1'b0, 1'b0, 8'h77);
      vec_cnt++;
      if (stat_s !== exp_stat(1) || io_dout !== 8'h77) begin
         err_cnt++;
         $display("FAIL empty_pop_then_push: got stat=%b dout=%h, need stat=%b dout=77",
                  stat_s, io_dout, exp_stat(1));
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic test_errors;
      logic exp_flag;
`ifdef FIFO_ERR_EN
      exp_flag = 1'b1;
`else
      exp_flag = 1'b0;
`endif
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
      drive(1'b1, 1'b0, 1'b0, 8'hEE);
      vec_cnt++;
      if (io_overflow !== exp_flag || io_underflow !== 1'b0 || stat_s !== exp_stat(16)) begin
         err_cnt++;
         $display("FAIL overflow: got ovf=%b unf=%b stat=%b, need ovf=%b unf=0 stat=%b",
                  io_overflow, io_underflow, stat_s, exp_flag, exp_stat(16));
      end
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      vec_cnt++;
      if (io_overflow !== exp_flag || io_underflow !== exp_flag) begin
         err_cnt++;
         $display("FAIL underflow: got ovf=%b unf=%b, need ovf=%b unf=%b",
                  io_overflow, io_underflow, exp_flag, exp_flag);
      end
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      vec_cnt++;
      if (io_overflow !== 1'b0 || io_underflow !== 1'b0) begin
         err_cnt++;
         $display("FAIL clr_err: got ovf=%b unf=%b, need 0 0", io_overflow, io_underflow);
      end
      // Clear coincident with a pop on empty: the clear wins.
      drive(1'b0, 1'b1, 1'b1, 8'h00);
      vec_cnt++;
      if (io_underflow !== 1'b0) begin
         err_cnt++;
         $display("FAIL clr_wins: got unf=%b, need 0", io_underflow);
      end
   endtask

   initial begin
      vec_cnt    = 0;
      err_cnt    = 0;
      reset      = 1'b0;
      io_din     = 8'h00;
      io_push    = 1'b0;
      io_pop     = 1'b0;
      io_clr_err = 1'b0;
      #12 reset  = 1'b1;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_full_push_pop();
      test_empty_push_pop();
      test_errors();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
